// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = $clog2(N_REQ);

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic [ID_W-1:0] id_t;

    // One-hot decode of a grant index
    function automatic logic [N_REQ-1:0] id_to_onehot(id_t id);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << id;
    endfunction
endpackage

// File: rtl/pri_enc_8.sv
// 8-to-3 priority encoder: bit 7 is the highest priority; y = 0 when nothing is set.
module pri_enc_8 (
    input  logic [7:0] i,
    output logic [2:0] y,
    output logic       vld
);
    // Scan upward so the highest set bit is the last one written
    always_comb begin
        y = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (i[k]) y = 3'(k);
        end
    end

    assign vld = |i;
endmodule

// File: rtl/req_arbiter_8.sv
// 8-requester arbiter with registered one-hot grant, hold-until-release and a
// hold-timeout guard. Fixed priority (bit 7 highest) by default; define
// ARB_ROUND_ROBIN_EN to rotate priority past the last winner.
module req_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16  // max BUSY cycles per grant; 0 disables the timeout
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output id_t              gnt_id,
    output logic             gnt_vld,
    output logic             no_req,
    output logic             timeout
);
    // Counter only needs to reach MAX_HOLD-1; it saturates rather than wraps
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t       state;
    id_t              last_id;
    logic [CNT_W-1:0] hold_cnt;
    id_t              win_id;
    logic             win_vld;
    logic             hold_hit;
    logic             holder_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [N_REQ-1:0] masked;
    id_t              id_m, id_u;
    logic             vld_m, vld_u;

    // Only requesters below the last winner compete first; wrap to the full vector otherwise
    assign masked = req & ((8'h1 << last_id) - 8'h1);

    pri_enc_8 u_enc_masked (.i(masked), .y(id_m), .vld(vld_m));
    pri_enc_8 u_enc_full   (.i(req),    .y(id_u), .vld(vld_u));

    assign win_id  = vld_m ? id_m : id_u;
    assign win_vld = vld_u;
`else
    logic unused_last_id;

    pri_enc_8 u_enc (.i(req), .y(win_id), .vld(win_vld));

    // last_id is tracked in both modes but only steers the rotating build
    assign unused_last_id = ^last_id;
`endif

    assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign holder_req = req[gnt_id];
    assign gnt_vld    = |gnt;

    // Grant FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last_id  <= '0;
            hold_cnt <= '0;
            no_req   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            no_req  <= en && (req == '0);
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && win_vld) begin
                        state    <= BUSY;
                        gnt      <= id_to_onehot(win_id);
                        gnt_id   <= win_id;
                        last_id  <= win_id;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (rel || !holder_req || hold_hit) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        // Only flag a revoke when the counter alone ended the grant
                        timeout <= hold_hit && !rel && holder_req;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_req_arbiter_8;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld, no_req, timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    bit m_busy = 0;
    int m_id = 0, m_last = 0, m_cnt = 0;
    bit m_no_req = 0, m_to = 0;

    req_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld),
        .no_req(no_req), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner by walking the priority order directly
    function automatic int pick(logic [7:0] r, int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = last - 1; k >= 0; k--) if (r[k]) return k;
`endif
        for (int k = 7; k >= 0; k--) if (r[k]) return k;
        return 0;
    endfunction

    // Model advance on each rising edge from the inputs present at that edge
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_id = 0; m_last = 0; m_cnt = 0; m_no_req = 0; m_to = 0;
        end else begin
            bit nr, hit;
            nr   = en && (req == 8'h00);
            m_to = 0;
            if (!m_busy) begin
                if (en && req != 8'h00) begin
                    m_id = pick(req, m_last);
                    m_last = m_id;
                    m_busy = 1;
                    m_cnt = 0;
                end
            end else begin
                hit = (MAX_HOLD != 0) && (m_cnt + 1 >= MAX_HOLD);
                if (rel || !req[m_id] || hit) begin
                    m_to = hit && !rel && req[m_id];
                    m_busy = 0;
                    m_id = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_no_req = nr;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] eg;
            eg = m_busy ? (8'h01 << m_id) : 8'h00;
            check("m_gnt", gnt, eg);
            check("m_gnt_id", {5'b0, gnt_id}, 8'(m_id));
            check("m_gnt_vld", {7'b0, gnt_vld}, {7'b0, m_busy});
            check("m_no_req", {7'b0, no_req}, {7'b0, m_no_req});
            check("m_timeout", {7'b0, timeout}, {7'b0, m_to});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rot_exp[4];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rot_exp = '{3, 1, 3, 1};
`else
        rot_exp = '{3, 3, 3, 3};
`endif
        // reset
        rst = 1; step(); step();
        chk_en = 1'b1;
        check("rst_gnt", gnt, 8'h00);
        check("rst_gnt_id", {5'b0, gnt_id}, 8'h00);
        check("rst_vld_to_noreq", {5'b0, gnt_vld, timeout, no_req}, 8'h00);

        // enable gate, then priority pick
        rst = 0; en = 0; req = 8'b0100_0010;
        for (int c = 0; c < 5; c++) begin
            step();
            check("gate_gnt", gnt, 8'h00);
            check("gate_no_req", {7'b0, no_req}, 8'h00);
        end
        en = 1; step();
        check("pick_gnt", gnt, 8'b0100_0000);
        check("pick_id", {5'b0, gnt_id}, 8'd6);
        check("pick_vld", {7'b0, gnt_vld}, 8'd1);

        // release then idle
        rel = 1; step(); rel = 0;
        check("rel_gnt", gnt, 8'h00);
        req = 8'h00; step();
        check("idle_no_req", {7'b0, no_req}, 8'd1);
        check("idle_gnt", gnt, 8'h00);

        // rotation
        rst = 1; step(); rst = 0;
        req = 8'b0000_1010;
        for (int g = 0; g < 4; g++) begin
            step();
            check("rot_id", {5'b0, gnt_id}, 8'(rot_exp[g]));
            rel = 1; step(); rel = 0;
            check("rot_rel", gnt, 8'h00);
        end

        // timeout
        req = 8'h00; step();
        rst = 1; step(); rst = 0;
        req = 8'b0010_0000;
        for (int c = 0; c < 4; c++) begin
            step();
            check("to_hold_vld", {7'b0, gnt_vld}, 8'd1);
            check("to_hold_pulse", {7'b0, timeout}, 8'd0);
        end
        step();
        check("to_pulse", {7'b0, timeout}, 8'd1);
        check("to_drop", {7'b0, gnt_vld}, 8'd0);
        step();
        check("to_regrant_id", {5'b0, gnt_id}, 8'd5);
        check("to_pulse_once", {7'b0, timeout}, 8'd0);

        // reset mid-grant
        req = 8'h00; step();
        req = 8'b0100_0000; step();
        check("mid_id", {5'b0, gnt_id}, 8'd6);
        rst = 1; step();
        check("mid_rst_all", {gnt[4:0], gnt_id}, 8'h00);
        check("mid_rst_flags", {gnt[7:5], 2'b0, gnt_vld, timeout, no_req}, 8'h00);
        rst = 0; req = 8'b0000_0100; step();
        check("post_rst_id", {5'b0, gnt_id}, 8'd2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            rel = ($urandom_range(0, 7) == 0);
            step();
        end

        rst = 0; rel = 0; req = 8'h00; step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
